control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main decoder of the single-cycle MIPS CPU: maps op/funct (plus ALU zero flag) to datapath
//  controls for PC, register file, ALU, extender and data memory. Sits beside the datapath.
//  Decode is combinational; one halt flag register (clk, async reset) freezes the PC after HALT.
// PARAMETERS
//  OP_HALT  6'b111111  opcode that stops the CPU
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  op          in   6  instruction[31:26]
//  zero        in   1  ALU result==0 flag, current cycle
//  funct       in   6  instruction[5:0], used only when op==0
//  PCSrc       out  1  1 = branch target (PC+4+imm<<2)
//  PCWre       out  1  PC write enable
//  ALUSrcB     out  1  1 = extended immediate to ALU B
//  MemtoReg    out  1  1 = write-back from data memory
//  RegWrite    out  1  register file write enable
//  MemWrite    out  1  data memory write enable
//  ExtSel      out  1  1 = sign-extend imm16, 0 = zero-extend
//  RegDst      out  1  1 = rd, 0 = rt destination
//  ALUControl  out  4  ALU op code
//  jump        out  1  1 = jump target {PC+4[31:28],addr26,2'b00}
//  MemWea      out  1  copy of MemWrite (BRAM wea)
// BEHAVIOUR
//  ALUControl: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll,
//   1000 srl, 1001 lui (B<<16).
//  R-type op=000000, RegDst=1 RegWrite=1 ALUSrcB=0: funct 100000 add, 100010 sub, 100100 and,
//   100101 or, 100110 xor, 100111 nor, 101010 slt, 000000 sll, 000010 srl; other funct = NOP.
//  I-type, RegDst=0 ALUSrcB=1 RegWrite=1: addi 001000 / addiu 001001 add ExtSel=1;
//   slti 001010 slt ExtSel=1; andi 001100 and, ori 001101 or, xori 001110 xor, lui 001111 lui
//   with ExtSel=0.
//  lw 100011: add, ALUSrcB=1 ExtSel=1 MemtoReg=1 RegWrite=1.
//  sw 101011: add, ALUSrcB=1 ExtSel=1 MemWrite=MemWea=1, RegWrite=0.
//  beq 000100 / bne 000101: sub, ALUSrcB=0 ExtSel=1; PCSrc=zero (beq) or ~zero (bne).
//  j 000010: jump=1, no writes. PCSrc=0 for all non-branch ops.
//  Undefined op/funct = NOP: all enables 0, PCWre=1, ALUControl=0000, other outputs 0.
//  Defaults for unlisted outputs: 0; ALUControl=add; PCWre=1.
//  HALT (op==OP_HALT): PCWre=0 same cycle, all writes 0; halted<=1 on next rising clk.
//  halted=1: PCWre=0, RegWrite=MemWrite=MemWea=jump=PCSrc=0 regardless of op; only reset clears.
//  rst=1 (async, immediate): halted<=0; PCWre=1; RegWrite, MemWrite, MemWea, PCSrc, jump=0.
//   Release takes effect combinationally; decoding resumes same cycle.
//  zero affects only PCSrc; funct ignored when op!=0.
// STRUCTURE
//  Shared package cpu_pkg: opcode/funct localparams, ALUControl encodings, OP_HALT.
//  Optional sub-module alu_decoder (op,funct -> ALUControl); main decode + halt flop in top.
// TESTING
//  op=0 funct=100010 -> ALUControl=0001 RegDst=1 RegWrite=1 ALUSrcB=0 MemWrite=0 PCWre=1.
//  op=100011 -> MemtoReg=1 ALUSrcB=1 ExtSel=1 RegWrite=1; op=101011 -> MemWrite=MemWea=1 RegWrite=0.
//  op=000100: zero=1 -> PCSrc=1; zero=0 -> PCSrc=0. op=000101 inverse. op=000010 -> jump=1.
//  op=001101 -> ExtSel=0 ALUControl=0011; op=001111 -> ALUControl=1001 RegWrite=1.
//  op=111111, clk edge, then op=0 funct=100000 -> PCWre=0 RegWrite=0 persists; rst=1 mid-cycle
//   -> PCWre=1 immediately without clock; after release add decodes normally.
//  op=010101 (undefined) -> all enables 0, PCWre=1; sweep all 64 ops, check no X on outputs.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, funct and ALU encodings for the single-cycle MIPS control path
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_LUI = 4'b1001
  } alu_op_t;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} run_state_t;
  function automatic logic isRtypeFunct(input logic [5:0] funct);
    return funct inside {F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT};
  endfunction
endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: maps op/funct to the ALU operation; anything unlisted falls back to add
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] ALUControl
);
  alu_op_t aluOp;
  // pick the ALU operation from the opcode, or from funct for R-type
  always_comb begin
    aluOp = ALU_ADD;
    case (op)
      OP_RTYPE:
        case (funct)
          F_SUB:   aluOp = ALU_SUB;
          F_AND:   aluOp = ALU_AND;
          F_OR:    aluOp = ALU_OR;
          F_XOR:   aluOp = ALU_XOR;
          F_NOR:   aluOp = ALU_NOR;
          F_SLT:   aluOp = ALU_SLT;
          F_SLL:   aluOp = ALU_SLL;
          F_SRL:   aluOp = ALU_SRL;
          default: aluOp = ALU_ADD;
        endcase
      OP_SLTI:         aluOp = ALU_SLT;
      OP_ANDI:         aluOp = ALU_AND;
      OP_ORI:          aluOp = ALU_OR;
      OP_XORI:         aluOp = ALU_XOR;
      OP_LUI:          aluOp = ALU_LUI;
      OP_BEQ, OP_BNE:  aluOp = ALU_SUB;
      default:         aluOp = ALU_ADD;
    endcase
  end
  assign ALUControl = aluOp;
endmodule

// File: rtl/control_unit.sv
// control_unit: combinational main decoder plus a halt flag that freezes the PC after HALT
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic [5:0] funct,
  output logic       PCSrc,
  output logic       PCWre,
  output logic       ALUSrcB,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ExtSel,
  output logic       RegDst,
  output logic [3:0] ALUControl,
  output logic       jump,
  output logic       MemWea
);
  run_state_t state;
  logic halted, block;
  logic decPCSrc, decPCWre, decRegWrite, decMemWrite, decJump;
  alu_decoder aluDec (.op(op), .funct(funct), .ALUControl(ALUControl));
  // halt flag: set by a HALT fetch, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else if (op == OP_HALT) state <= HALTED;
  assign halted = state == HALTED;
  // main decode of the datapath steering and enables
  always_comb begin
    decPCSrc    = 1'b0;
    decPCWre    = 1'b1;
    decRegWrite = 1'b0;
    decMemWrite = 1'b0;
    decJump     = 1'b0;
    ALUSrcB     = 1'b0;
    MemtoReg    = 1'b0;
    ExtSel      = 1'b0;
    RegDst      = 1'b0;
    case (op)
      OP_RTYPE: begin
        RegDst      = isRtypeFunct(funct);
        decRegWrite = isRtypeFunct(funct);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ALUSrcB     = 1'b1;
        ExtSel      = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ALUSrcB     = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_LW: begin
        ALUSrcB     = 1'b1;
        ExtSel      = 1'b1;
        MemtoReg    = 1'b1;
        decRegWrite = 1'b1;
      end
      OP_SW: begin
        ALUSrcB     = 1'b1;
        ExtSel      = 1'b1;
        decMemWrite = 1'b1;
      end
      OP_BEQ: begin
        ExtSel   = 1'b1;
        decPCSrc = zero;
      end
      OP_BNE: begin
        ExtSel   = 1'b1;
        decPCSrc = ~zero;
      end
      OP_J:    decJump  = 1'b1;
      OP_HALT: decPCWre = 1'b0;
      default: ;
    endcase
  end
  assign block    = halted | rst;
  assign PCWre    = rst | (decPCWre & ~halted);
  assign PCSrc    = decPCSrc & ~block;
  assign RegWrite = decRegWrite & ~block;
  assign MemWrite = decMemWrite & ~block;
  assign MemWea   = MemWrite;
  assign jump     = decJump & ~block;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors checked against a spec-level decode model every cycle
module tb_control_unit;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic PCSrc, PCWre, ALUSrcB, MemtoReg, RegWrite, MemWrite, ExtSel, RegDst, jump, MemWea;
  logic [3:0] ALUControl;
  int total = 0, bad = 0;
  logic modelHalted = 1'b0;
  logic [13:0] outs;

  control_unit dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .funct(funct),
    .PCSrc(PCSrc), .PCWre(PCWre), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ExtSel(ExtSel), .RegDst(RegDst),
    .ALUControl(ALUControl), .jump(jump), .MemWea(MemWea)
  );

  always #5 clk = ~clk;

  assign outs = {PCSrc, PCWre, ALUSrcB, MemtoReg, RegWrite, MemWrite, ExtSel, RegDst,
                 ALUControl, jump, MemWea};

  // field order: PCSrc PCWre ALUSrcB MemtoReg RegWrite MemWrite ExtSel RegDst ALU[4] jump MemWea
  function automatic logic [13:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input logic z, input logic h, input logic r);
    logic pcsrc = 0, pcwre = 1, srcb = 0, m2r = 0, rw = 0, mw = 0, ext = 0, rd = 0, j = 0;
    logic [3:0] alu = 4'd0;
    int rIdx;
    logic [5:0] rFuncts [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010, 6'b000000, 6'b000010};
    rIdx = -1;
    for (int i = 0; i < 9; i++) if (rFuncts[i] == f) rIdx = i;
    if (o == 6'b000000) begin
      if (rIdx >= 0) begin alu = 4'(rIdx); rd = 1; rw = 1; end
    end else if (o == 6'b001000 || o == 6'b001001) begin srcb = 1; ext = 1; rw = 1; end
    else if (o == 6'b001010) begin srcb = 1; ext = 1; rw = 1; alu = 4'b0110; end
    else if (o >= 6'b001100 && o <= 6'b001111) begin
      srcb = 1; rw = 1;
      alu = (o == 6'b001111) ? 4'b1001 : 4'(32'(o) - 12 + 2);
    end
    else if (o == 6'b100011) begin srcb = 1; ext = 1; m2r = 1; rw = 1; end
    else if (o == 6'b101011) begin srcb = 1; ext = 1; mw = 1; end
    else if (o == 6'b000100 || o == 6'b000101) begin
      ext = 1; alu = 4'b0001; pcsrc = (o == 6'b000100) ? z : ~z;
    end
    else if (o == 6'b000010) j = 1;
    else if (o == 6'b111111) pcwre = 0;
    if (h || r) begin pcsrc = 0; rw = 0; mw = 0; j = 0; pcwre = 0; end
    if (r) pcwre = 1;
    return {pcsrc, pcwre, srcb, m2r, rw, mw, ext, rd, alu, j, mw};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h op=%b funct=%b zero=%b rst=%b t=%0t",
               name, got, exp, op, funct, zero, rst, $time);
    end
  endtask

  // reference halt flag: a HALT fetch sets it, reset clears it
  always @(posedge clk or posedge rst)
    if (rst) modelHalted <= 1'b0;
    else if (op == 6'b111111) modelHalted <= 1'b1;

  // every-cycle compare against the model, plus an X check on all outputs
  always @(negedge clk) begin
    chk("model", 32'(outs), 32'(model(op, funct, zero, modelHalted, rst)));
    chk("noX", 32'($isunknown(outs)), 32'd0);
  end

  task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk);
    #1 op = o; funct = f; zero = z;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_PCWre", 32'(PCWre), 32'd1);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(6'b000000, 6'b100010, 1'b0);
    chk("sub_alu", 32'(ALUControl), 32'b0001);
    chk("sub_ctl", 32'({RegDst, RegWrite, ALUSrcB, MemWrite, PCWre}), 32'b11001);
    apply(6'b100011, 6'b000000, 1'b0);
    chk("lw_ctl", 32'({MemtoReg, ALUSrcB, ExtSel, RegWrite}), 32'b1111);
    apply(6'b101011, 6'b000000, 1'b0);
    chk("sw_ctl", 32'({MemWrite, MemWea, RegWrite}), 32'b110);
    apply(6'b000100, 6'b000000, 1'b1);
    chk("beq_taken", 32'(PCSrc), 32'd1);
    apply(6'b000100, 6'b000000, 1'b0);
    chk("beq_not", 32'(PCSrc), 32'd0);
    apply(6'b000101, 6'b000000, 1'b1);
    chk("bne_not", 32'(PCSrc), 32'd0);
    apply(6'b000101, 6'b000000, 1'b0);
    chk("bne_taken", 32'(PCSrc), 32'd1);
    apply(6'b000010, 6'b000000, 1'b0);
    chk("j_jump", 32'({jump, RegWrite, MemWrite}), 32'b100);
    apply(6'b001101, 6'b000000, 1'b0);
    chk("ori", 32'({ExtSel, ALUControl}), 32'b00011);
    apply(6'b001111, 6'b000000, 1'b0);
    chk("lui", 32'({ALUControl, RegWrite}), 32'b10011);
    apply(6'b010101, 6'b000000, 1'b0);
    chk("undef_op", 32'(outs), 32'b01000000000000);
    apply(6'b000000, 6'b111111, 1'b0);
    chk("undef_funct", 32'(outs), 32'b01000000000000);
    for (int i = 0; i < 63; i++) apply(6'(i), 6'($urandom_range(0, 63)), 1'($urandom));
    for (int i = 0; i < 64; i++) apply(6'b000000, 6'(i), 1'b0);
    apply(6'b111111, 6'b000000, 1'b0);
    chk("halt_same_cycle", 32'({PCWre, RegWrite, MemWrite}), 32'b000);
    apply(6'b000000, 6'b100000, 1'b0);
    chk("halted_add", 32'({PCWre, RegWrite}), 32'b00);
    apply(6'b000010, 6'b000000, 1'b0);
    chk("halted_j", 32'({PCWre, jump}), 32'b00);
    apply(6'b000100, 6'b000000, 1'b1);
    chk("halted_beq", 32'(PCSrc), 32'd0);
    apply(6'b000000, 6'b100000, 1'b0);
    chk("halted_persist", 32'({PCWre, RegWrite}), 32'b00);
    rst = 1'b1;
    #1;
    chk("rst_async_PCWre", 32'(PCWre), 32'd1);
    chk("rst_async_RegWrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("resume_add", 32'({PCWre, RegWrite, RegDst, ALUControl}), 32'b1110000);
    apply(6'b000000, 6'b100000, 1'b0);
    chk("resume_next", 32'({PCWre, RegWrite}), 32'b11);
    @(posedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
